// File: rtl/tone_div_multi.sv
// tone_div_multi: N-channel programmable square-wave tone divider.
// Each channel runs its own period/duty counter. A shadow register per
// channel holds new settings until the next period boundary, silence, or a
// global sync, so tone changes never produce runt or stretched pulses.
module tone_div_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 24,
    parameter int DUTY_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        load_i,
    input  logic [CHANNELS*CNT_W-1:0]  period_i,
    input  logic [CHANNELS*DUTY_W-1:0] duty_i,
    input  logic                       sync_i,
    output logic [CHANNELS-1:0]        wave_o,
    output logic [CHANNELS-1:0]        wrap_o,
    output logic [CHANNELS-1:0]        pend_o
);

    // High-phase length: full-width product, then drop the duty fraction bits.
    // Because duty < 2^DUTY_W the result is always strictly below the period.
    function automatic logic [CNT_W-1:0] hi_from_duty(
        input logic [CNT_W-1:0]  per,
        input logic [DUTY_W-1:0] duty
    );
        logic [CNT_W+DUTY_W-1:0] prod;
        prod = {{DUTY_W{1'b0}}, per} * {{CNT_W{1'b0}}, duty};
        return prod[CNT_W+DUTY_W-1:DUTY_W];
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  act_per;
        logic [CNT_W-1:0]  hi_cnt;
        logic [CNT_W-1:0]  pend_per;
        logic [DUTY_W-1:0] pend_duty;
        logic              pend_v;
        logic              wave_r;
        logic              wrap_r;
        logic              silent;
        logic              at_wrap;
        logic              apply;

        // Channel status: silence, end-of-period, and whether the shadow takes effect now.
        always_comb begin
            silent  = (act_per < CNT_W'(2));
            at_wrap = !silent && (cnt == act_per - CNT_W'(1));
            apply   = pend_v && (silent || at_wrap || sync_i);
        end

        // Period counter, active settings and registered wave/wrap outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt     <= '0;
                act_per <= '0;
                hi_cnt  <= '0;
                wave_r  <= 1'b0;
                wrap_r  <= 1'b0;
            end else begin
                wave_r <= !silent && (cnt < hi_cnt);
                wrap_r <= at_wrap;
                if (apply) begin
                    act_per <= pend_per;
                    hi_cnt  <= hi_from_duty(pend_per, pend_duty);
                    cnt     <= '0;
                end else if (silent || at_wrap || sync_i) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        // Shadow valid flag: a load wins over a same-edge apply so the new value stays pending.
        always_ff @(posedge clk) begin
            if (rst) begin
                pend_v <= 1'b0;
            end else if (load_i[c]) begin
                pend_v <= 1'b1;
            end else if (apply) begin
                pend_v <= 1'b0;
            end
        end

        // Shadow data capture; the last load before an apply is the one used.
        always_ff @(posedge clk) begin
            if (load_i[c]) begin
                pend_per  <= period_i[c*CNT_W +: CNT_W];
                pend_duty <= duty_i[c*DUTY_W +: DUTY_W];
            end
        end

        assign wave_o[c] = wave_r;
        assign wrap_o[c] = wrap_r;
        assign pend_o[c] = pend_v;
    end

endmodule

// File: tb/tb_tone_div_multi.sv
// Directed testbench for tone_div_multi with hand-computed expected patterns.
module tb_tone_div_multi;

    localparam int CHANNELS = 4;
    localparam int CNT_W    = 24;
    localparam int DUTY_W   = 8;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [CHANNELS-1:0]        load_i = '0;
    logic [CHANNELS*CNT_W-1:0]  period_i = '0;
    logic [CHANNELS*DUTY_W-1:0] duty_i = '0;
    logic                       sync_i = 1'b0;
    logic [CHANNELS-1:0]        wave_o;
    logic [CHANNELS-1:0]        wrap_o;
    logic [CHANNELS-1:0]        pend_o;

    int checks = 0;
    int errors = 0;

    tone_div_multi #(
        .CHANNELS(CHANNELS),
        .CNT_W   (CNT_W),
        .DUTY_W  (DUTY_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_i),
        .period_i(period_i),
        .duty_i  (duty_i),
        .sync_i  (sync_i),
        .wave_o  (wave_o),
        .wrap_o  (wrap_o),
        .pend_o  (pend_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled and inputs changed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ld(input int c, input int per, input int duty);
        load_i[c] = 1'b1;
        period_i[c*CNT_W +: CNT_W] = CNT_W'(per);
        duty_i[c*DUTY_W +: DUTY_W] = DUTY_W'(duty);
    endtask

    task automatic clr_ld();
        load_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic ew, er, ep, e0, e1;
        int   j;
        #1;

        // ---- Reset state and basic 4-cycle, 50% duty tone on ch0
        do_reset();
        chk("rst_wave", 32'(wave_o), 32'h0);
        chk("rst_wrap", 32'(wrap_o), 32'h0);
        chk("rst_pend", 32'(pend_o), 32'h0);
        set_ld(0, 4, 128);
        tick();
        clr_ld();
        chk("t1_pend_set", 32'(pend_o[0]), 32'h1);
        tick();
        chk("t1_pend_clr", 32'(pend_o[0]), 32'h0);
        chk("t1_wave_pre", 32'(wave_o[0]), 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("t1_wave_k%0d", k), 32'(wave_o[0]), 32'((k % 4) < 2));
            chk($sformatf("t1_wrap_k%0d", k), 32'(wrap_o[0]), 32'((k % 4) == 3));
        end

        // ---- ch1: period 10/hi 2, reloaded mid-period to period 6/hi 3
        do_reset();
        set_ld(1, 10, 64);
        tick();
        clr_ld();
        tick();
        for (int k = 0; k < 22; k++) begin
            tick();
            if (k < 10) begin
                ew = (k < 2);
                er = (k == 9);
            end else begin
                j  = k - 10;
                ew = ((j % 6) < 3);
                er = ((j % 6) == 5);
            end
            ep = (k >= 5 && k <= 8);
            chk($sformatf("t2_wave_k%0d", k), 32'(wave_o[1]), 32'(ew));
            chk($sformatf("t2_wrap_k%0d", k), 32'(wrap_o[1]), 32'(er));
            chk($sformatf("t2_pend_k%0d", k), 32'(pend_o[1]), 32'(ep));
            if (k == 4) set_ld(1, 6, 128);
            if (k == 5) clr_ld();
        end

        // ---- ch2: last-write-wins shadow, then a load landing on a wrap edge
        do_reset();
        set_ld(2, 4, 128);
        tick();
        clr_ld();
        tick();
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k < 4) begin
                ew = (k < 2);
                er = (k == 3);
            end else if (k < 16) begin
                j  = k - 4;
                ew = (j < 6);
                er = (j == 11);
            end else if (k < 22) begin
                j  = k - 16;
                ew = (j < 3);
                er = (j == 5);
            end else begin
                j  = k - 22;
                ew = ((j % 8) < 2);
                er = ((j % 8) == 7);
            end
            ep = (k == 1 || k == 2) || (k >= 10 && k <= 20);
            chk($sformatf("t3_wave_k%0d", k), 32'(wave_o[2]), 32'(ew));
            chk($sformatf("t3_wrap_k%0d", k), 32'(wrap_o[2]), 32'(er));
            chk($sformatf("t3_pend_k%0d", k), 32'(pend_o[2]), 32'(ep));
            if (k == 0)  set_ld(2, 8, 128);
            if (k == 1)  set_ld(2, 12, 128);
            if (k == 2)  clr_ld();
            if (k == 9)  set_ld(2, 6, 128);
            if (k == 10) clr_ld();
            if (k == 14) set_ld(2, 8, 64);
            if (k == 15) clr_ld();
        end

        // ---- Sync realigns ch0 (period 5) and ch1 (period 7)
        do_reset();
        set_ld(0, 5, 128);
        set_ld(1, 7, 128);
        tick();
        clr_ld();
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 3) begin
                e0 = (k < 2);
                e1 = (k < 3);
            end else if (k == 3) begin
                e0 = 1'b0;
                e1 = 1'b0;
            end else begin
                j  = k - 4;
                e0 = (j < 2);
                e1 = (j < 3);
            end
            chk($sformatf("t4_wave0_k%0d", k), 32'(wave_o[0]), 32'(e0));
            chk($sformatf("t4_wave1_k%0d", k), 32'(wave_o[1]), 32'(e1));
            chk($sformatf("t4_wrap_k%0d", k), 32'(wrap_o[1:0]), 32'h0);
            if (k == 2) sync_i = 1'b1;
            if (k == 3) sync_i = 1'b0;
        end

        // ---- ch3: periods 1 and 0 are silent; duty 0 counts but stays low
        do_reset();
        set_ld(3, 1, 128);
        tick();
        clr_ld();
        tick();
        set_ld(3, 0, 128);
        tick();
        clr_ld();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("t5_sil_wave_k%0d", k), 32'(wave_o[3]), 32'h0);
            chk($sformatf("t5_sil_wrap_k%0d", k), 32'(wrap_o[3]), 32'h0);
        end
        chk("t5_sil_pend", 32'(pend_o[3]), 32'h0);
        set_ld(3, 8, 0);
        tick();
        clr_ld();
        tick();
        for (int k = 0; k < 17; k++) begin
            tick();
            chk($sformatf("t5_d0_wave_k%0d", k), 32'(wave_o[3]), 32'h0);
            chk($sformatf("t5_d0_wrap_k%0d", k), 32'(wrap_o[3]), 32'((k % 8) == 7));
        end

        // ---- Reset mid-period discards a pending load
        do_reset();
        set_ld(0, 4, 128);
        tick();
        clr_ld();
        tick();
        tick();
        chk("t6_running", 32'(wave_o[0]), 32'h1);
        set_ld(0, 10, 128);
        tick();
        clr_ld();
        chk("t6_pend_before", 32'(pend_o[0]), 32'h1);
        rst = 1'b1;
        tick();
        chk("t6_rst_wave", 32'(wave_o), 32'h0);
        chk("t6_rst_wrap", 32'(wrap_o), 32'h0);
        chk("t6_rst_pend", 32'(pend_o), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("t6_post_wave_k%0d", k), 32'(wave_o), 32'h0);
            chk($sformatf("t6_post_wrap_k%0d", k), 32'(wrap_o), 32'h0);
            chk($sformatf("t6_post_pend_k%0d", k), 32'(pend_o), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
